// File: rtl/bus_pkg.sv
// Shared types and address-window constants for the peripheral bus controller.
package bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    RESP   = 2'b11
  } state_e;

  // Encoding doubles as the read-mux select code.
  typedef enum logic [SEL_W-1:0] {
    RAM   = 2'b00,
    UART  = 2'b01,
    SW    = 2'b10,
    GAUSS = 2'b11
  } slave_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic read;
    logic we_ram;
    logic we_uart;
    logic we_gauss;
  } strobe_t;

  localparam logic [ADDR_W-1:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] UART_BASE  = 32'h0000_2000;
  localparam logic [ADDR_W-1:0] UART_MASK  = 32'hFFFF_FFF0;
  localparam logic [ADDR_W-1:0] SW_BASE    = 32'h0000_2010;
  localparam logic [ADDR_W-1:0] SW_MASK    = 32'hFFFF_FFF0;
  localparam logic [ADDR_W-1:0] GAUSS_BASE = 32'h0000_2020;
  localparam logic [ADDR_W-1:0] GAUSS_MASK = 32'hFFFF_FFF0;

  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/periph_bus_ctrl_if.sv
// Core load/store port and slave-side signals of the peripheral bus controller.
interface periph_bus_ctrl_if;
  import bus_pkg::*;

  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              ready_o;
  logic              err_o;

  logic [SEL_W-1:0]  select_o;
  logic              read_o;
  logic              we_ram_o;
  logic              we_uart_o;
  logic              we_gauss_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] wdata_o;
  logic              ram_rdy_i;
  logic              uart_rdy_i;
  logic              gauss_rdy_i;
  logic [DATA_W-1:0] mux_data_i;

  // Controller view: serves the core, drives the slaves.
  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    input  ram_rdy_i, uart_rdy_i, gauss_rdy_i, mux_data_i,
    output rdata_o, ready_o, err_o,
    output select_o, read_o, we_ram_o, we_uart_o, we_gauss_o, addr_o, wdata_o
  );

  // Environment view: the core plus the slaves and the read mux.
  modport master (
    output req_i, we_i, addr_i, wdata_i,
    output ram_rdy_i, uart_rdy_i, gauss_rdy_i, mux_data_i,
    input  rdata_o, ready_o, err_o,
    input  select_o, read_o, we_ram_o, we_uart_o, we_gauss_o, addr_o, wdata_o
  );

endinterface

// File: rtl/addr_decode.sv
// Combinational address decoder: slave code, window hit and illegal-write flag.
module addr_decode
  import bus_pkg::*;
#(
  parameter int unsigned RAM_AW = 12
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output slave_e            slave,
  output logic              hit,
  output logic              illegal
);

  localparam logic [ADDR_W-1:0] RAM_MASK = ~((32'd1 << RAM_AW) - 32'd1);

  always_comb begin
    slave = RAM;
    hit   = 1'b0;
    if (in_window(addr, RAM_BASE, RAM_MASK)) begin
      slave = RAM;
      hit   = 1'b1;
    end else if (in_window(addr, UART_BASE, UART_MASK)) begin
      slave = UART;
      hit   = 1'b1;
    end else if (in_window(addr, SW_BASE, SW_MASK)) begin
      slave = SW;
      hit   = 1'b1;
    end else if (in_window(addr, GAUSS_BASE, GAUSS_MASK)) begin
      slave = GAUSS;
      hit   = 1'b1;
    end
  end

  // Switches are read-only.
  assign illegal = hit && we && (slave == SW);

endmodule

// File: rtl/periph_bus_ctrl.sv
// Sequences one core load/store through the decoded slave, with wait states,
// timeout and error responses, returning a one-cycle ready pulse.
module periph_bus_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned RAM_AW  = 12
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  periph_bus_ctrl_if.slave bus
);

  localparam int unsigned      CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e            state_q;
  slave_e            sel_q;
  slave_e            dec_slave;
  logic              dec_hit;
  logic              dec_illegal;
  bus_req_t          req_q;
  strobe_t           strobe_q;
  logic              ready_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              expired_q;
  logic              slave_rdy;

  addr_decode #(
    .RAM_AW (RAM_AW)
  ) u_addr_decode (
    .addr    (bus.addr_i),
    .we      (bus.we_i),
    .slave   (dec_slave),
    .hit     (dec_hit),
    .illegal (dec_illegal)
  );

  // Effective ready of the selected slave; switches never stall.
  always_comb begin
    slave_rdy = 1'b0;
    case (sel_q)
      RAM:     slave_rdy = bus.ram_rdy_i;
      UART:    slave_rdy = bus.uart_rdy_i;
      SW:      slave_rdy = 1'b1;
      GAUSS:   slave_rdy = bus.gauss_rdy_i;
      default: slave_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      sel_q     <= RAM;
      req_q     <= '0;
      strobe_q  <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_i) begin
            req_q <= '{we: bus.we_i, addr: bus.addr_i, wdata: bus.wdata_i};
            sel_q <= dec_slave;
            if (!dec_hit || dec_illegal) begin
              state_q <= RESP;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q           <= ACCESS;
              strobe_q.read     <= !bus.we_i;
              strobe_q.we_ram   <= bus.we_i && (dec_slave == RAM);
              strobe_q.we_uart  <= bus.we_i && (dec_slave == UART);
              strobe_q.we_gauss <= bus.we_i && (dec_slave == GAUSS);
            end
          end
        end

        ACCESS, WAIT: begin
          if (slave_rdy) begin
            state_q  <= RESP;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            rdata_q  <= req_q.we ? '0 : bus.mux_data_i;
            strobe_q <= '0;
          end else if (state_q == ACCESS) begin
            state_q   <= WAIT;
            cnt_q     <= '0;
            expired_q <= 1'b0;
          end else if (expired_q) begin
            state_q  <= RESP;
            ready_q  <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= '0;
            strobe_q <= '0;
          end else begin
            // Saturating count; expiry is registered the cycle after saturation.
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            expired_q <= (cnt_q == CNT_MAX);
          end
        end

        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdata_o    = rdata_q;
  assign bus.ready_o    = ready_q;
  assign bus.err_o      = err_q;
  assign bus.select_o   = sel_q;
  assign bus.read_o     = strobe_q.read;
  assign bus.we_ram_o   = strobe_q.we_ram;
  assign bus.we_uart_o  = strobe_q.we_uart;
  assign bus.we_gauss_o = strobe_q.we_gauss;
  assign bus.addr_o     = req_q.addr;
  assign bus.wdata_o    = req_q.wdata;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Scoreboard bench for periph_bus_ctrl: directed accesses push expected responses,
// a monitor pops and compares on every ready_o pulse.
module tb_periph_bus_ctrl;
  import bus_pkg::*;

  localparam int unsigned TIMEOUT = 15;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int unsigned issue;
    int unsigned lat;
  } exp_t;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b1;

  periph_bus_ctrl_if bus();

  periph_bus_ctrl #(
    .TIMEOUT (TIMEOUT),
    .RAM_AW  (12)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned cyc         = 0;
  int unsigned n_ready     = 0;
  int unsigned n_push      = 0;
  int unsigned n_read      = 0;
  int unsigned n_we_ram    = 0;
  int unsigned n_we_uart   = 0;
  int unsigned n_we_gauss  = 0;
  int unsigned b_read, b_we_ram, b_we_uart, b_we_gauss, r0;
  int unsigned stall       = 0;
  int unsigned scnt        = 0;
  logic [1:0]  last_sel    = 2'b00;
  logic [31:0] last_wdata  = '0;
  logic        strobe, rdy;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({bus.rdata_o, bus.ready_o, bus.err_o, bus.select_o, bus.read_o,
                 bus.we_ram_o, bus.we_uart_o, bus.we_gauss_o, bus.addr_o, bus.wdata_o});
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Slave + read-mux model: ready after 'stall' strobe cycles, data by select.
  initial forever begin
    @(negedge clk_i);
    strobe = bus.read_o | bus.we_ram_o | bus.we_uart_o | bus.we_gauss_o;
    if (strobe) begin
      rdy = (scnt >= stall);
      scnt++;
      if (bus.read_o)     n_read++;
      if (bus.we_ram_o)   n_we_ram++;
      if (bus.we_uart_o)  n_we_uart++;
      if (bus.we_gauss_o) n_we_gauss++;
      last_sel = bus.select_o;
      if (bus.we_ram_o | bus.we_uart_o | bus.we_gauss_o) last_wdata = bus.wdata_o;
    end else begin
      rdy  = 1'b0;
      scnt = 0;
    end
    bus.ram_rdy_i   = rdy;
    bus.uart_rdy_i  = rdy;
    bus.gauss_rdy_i = rdy;
    case (bus.select_o)
      2'b00:   bus.mux_data_i = 32'hDEAD_BEEF;
      2'b01:   bus.mux_data_i = 32'h0000_0055;
      2'b10:   bus.mux_data_i = 32'h0000_00A5;
      default: bus.mux_data_i = 32'h0BAD_CAFE;
    endcase
  end

  // Monitor: every completion is matched against the oldest expected response.
  initial forever begin
    @(negedge clk_i);
    if (rst_n_i && bus.ready_o) begin
      n_ready++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ready: got ready_o=1, expected no completion");
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_rdata"}, 128'(bus.rdata_o), 128'(mon_e.rdata));
        check({mon_e.tag, "_err"}, 128'(bus.err_o), 128'(mon_e.err));
        check({mon_e.tag, "_latency"}, 128'(cyc - mon_e.issue), 128'(mon_e.lat));
        check({mon_e.tag, "_resp_strobes"},
              128'({bus.read_o, bus.we_ram_o, bus.we_uart_o, bus.we_gauss_o}), 128'(0));
      end
    end
  end

  task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input int unsigned exp_lat,
                           input int unsigned stall_cycles);
    exp_t e;
    bit   done;
    b_read     = n_read;
    b_we_ram   = n_we_ram;
    b_we_uart  = n_we_uart;
    b_we_gauss = n_we_gauss;
    stall      = stall_cycles;
    @(negedge clk_i);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    e.tag   = tag;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.issue = cyc;
    e.lat   = exp_lat;
    sb.push_back(e);
    n_push++;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (bus.ready_o) done = 1'b1;
    end
    bus.req_i = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_no_ready: got no ready_o, expected one within 200 cycles", tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    #2 rst_n_i = 1'b0;
    #1 check("reset_state", outs(), 128'(0));
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;

    do_access("ram_read", 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
    check("ram_read_strobe", 128'(n_read - b_read), 128'(1));
    check("ram_read_select", 128'(last_sel), 128'(2'b00));

    do_access("uart_write", 1'b1, 32'h0000_2000, 32'h41, 32'h0, 1'b0, 5, 3);
    check("uart_we_cycles", 128'(n_we_uart - b_we_uart), 128'(4));
    check("uart_wdata", 128'(last_wdata), 128'(32'h41));
    check("uart_no_read", 128'(n_read - b_read), 128'(0));

    do_access("sw_read", 1'b0, 32'h0000_2010, 32'h0, 32'h0000_00A5, 1'b0, 2, 5);
    check("sw_read_select", 128'(last_sel), 128'(2'b10));
    @(negedge clk_i);
    check("rdata_hold", 128'(bus.rdata_o), 128'(32'h0000_00A5));

    do_access("sw_write", 1'b1, 32'h0000_2014, 32'h77, 32'h0, 1'b1, 1, 0);
    check("sw_write_strobes", 128'((n_read - b_read) + (n_we_ram - b_we_ram) +
          (n_we_uart - b_we_uart) + (n_we_gauss - b_we_gauss)), 128'(0));

    do_access("unmapped_read", 1'b0, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 1, 0);
    check("unmapped_strobes", 128'(n_read - b_read), 128'(0));

    do_access("ram_top", 1'b0, 32'h0000_0FFC, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
    do_access("ram_past_top", 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1, 0);

    do_access("gauss_write", 1'b1, 32'h0000_202C, 32'h1234_5678, 32'h0, 1'b0, 3, 1);
    check("gauss_we_cycles", 128'(n_we_gauss - b_we_gauss), 128'(2));

    do_access("gauss_timeout", 1'b0, 32'h0000_2020, 32'h0, 32'h0, 1'b1, TIMEOUT + 4, 1000);
    check("timeout_read_cycles", 128'(n_read - b_read), 128'(TIMEOUT + 3));

    // Abort a stalled gauss read with reset: no completion may follow.
    stall = 1000;
    r0    = n_ready;
    @(negedge clk_i);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 32'h0000_2024;
    repeat (4) @(negedge clk_i);
    bus.req_i = 1'b0;
    check("mid_access_read", 128'(bus.read_o), 128'(1));
    #2 rst_n_i = 1'b0;
    #1 check("reset_mid_access", outs(), 128'(0));
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("no_ready_after_abort", 128'(n_ready), 128'(r0));

    do_access("ram_after_reset", 1'b0, 32'h0000_0080, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);

    repeat (2) @(negedge clk_i);
    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    check("ready_count", 128'(n_ready), 128'(n_push));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/periph_bus_ctrl.md
# periph_bus_ctrl

Sequencer between the core's load/store port and the four data slaves: RAM, UART, switches and the gauss accelerator. It decodes each access address, drives the slave-select code and the read strobe for the read-data mux, and drives the per-slave write strobes. It waits for the slave's ready, captures the muxed read data and returns a one-cycle `ready_o` to stall the single-cycle core. Unmapped, illegal or timed-out accesses end with an error response instead of hanging the core.

## Interface

**Parameters**
- `TIMEOUT`, default 15: maximum number of cycles spent in WAIT before an error response.
- `RAM_AW`, default 12: RAM byte-address width. RAM window is `0x0000_0000` to `0x0000_0FFF`.

**Ports** (name, direction, width, meaning)
- Clock and reset:
  - `clk_i`, in, 1: clock. This is the only clock domain.
  - `rst_n_i`, in, 1: reset. Asynchronous assert, active-low.
- Core side:
  - `req_i`, in, 1: access request. Held by the core until `ready_o`.
  - `we_i`, in, 1: 1 = write, 0 = read.
  - `addr_i`, in, 32: byte address.
  - `wdata_i`, in, 32: write data.
  - `rdata_o`, out, 32: read data. Valid while `ready_o`=1.
  - `ready_o`, out, 1: one-cycle completion pulse.
  - `err_o`, out, 1: error flag. Valid with `ready_o`.
- Slave side:
  - `select_o`, out, 2: read-mux select. 00 = RAM, 01 = UART, 10 = switches, 11 = gauss.
  - `read_o`, out, 1: read strobe to the mux and slaves.
  - `we_ram_o`, out, 1: RAM write strobe.
  - `we_uart_o`, out, 1: UART write strobe.
  - `we_gauss_o`, out, 1: gauss write strobe.
  - `addr_o`, out, 32: registered address.
  - `wdata_o`, out, 32: registered write data.
  - `ram_rdy_i`, in, 1: RAM ready.
  - `uart_rdy_i`, in, 1: UART ready.
  - `gauss_rdy_i`, in, 1: gauss ready.
  - `mux_data_i`, in, 32: read-mux output.

## Operation

**Address map**
- RAM: `0x0000_0000` to `0x0000_0FFF`.
- UART: `0x0000_2000` to `0x0000_200F`.
- Switches: `0x0000_2010` to `0x0000_201F`. Read-only.
- Gauss: `0x0000_2020` to `0x0000_202F`.
- Any other address is unmapped.

**States**
- IDLE:
  - On `req_i`=1, register `addr_i`, `we_i` and `wdata_i`, and decode the slave.
  - Unmapped address, or write to switches: go to RESP with the error flag set.
  - Otherwise: go to ACCESS.
- ACCESS and WAIT:
  - `select_o` holds the decoded code.
  - For a read, `read_o`=1. For a write, the matching `we_*_o`=1.
  - Effective ready is the slave's `*_rdy_i`. For switches it is a constant 1.
  - Ready=1: capture `mux_data_i` (reads only) into `rdata_o` and go to RESP.
  - Ready=0 in ACCESS: go to WAIT and clear the timeout counter.
  - In WAIT, ready=0: increment the counter. When the counter reaches `TIMEOUT`, go to RESP with the error flag set.
- RESP:
  - `ready_o`=1 for exactly one cycle.
  - `err_o` shows the error flag.
  - All strobes are 0. `select_o` holds its value.
  - Next state is IDLE.

**Rules**
- `req_i` is ignored outside IDLE.
- On an error, `rdata_o`=0.
- On a write, `rdata_o`=0.
- `rdata_o` and `err_o` hold their values until the next RESP.
- Strobes are never asserted in IDLE or RESP.
- At most one `we_*_o` is high at any time, and never together with `read_o`.
- A read of switches completes with no wait (ready is a constant 1).
- Timeout counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing

- **Reset values:** state IDLE; all outputs 0, including `select_o`=00, `rdata_o`=0, `addr_o`=0 and `wdata_o`=0.
- **Reset mid-access:** the access is aborted. No `ready_o` is issued for it, and strobes drop asynchronously.
- **Minimum latency:** `req_i` sampled at edge N, ACCESS in cycle N+1, `ready_o` in cycle N+2.
- **Wait states:** each cycle of slave ready=0 adds one cycle of latency.
- **Timeout path:** `ready_o`+`err_o` arrive exactly `TIMEOUT`+2 cycles after the WAIT state is entered.
- **Error path:** an unmapped or illegal access gives `ready_o` in cycle N+1.
- **Back-to-back requests:** the core drops `req_i` in the cycle after `ready_o`, and the next request is sampled no earlier than the IDLE cycle that follows RESP.
- **Early ready:** a slave ready that arrives in the same cycle as the ACCESS entry is honoured.
- **Ready outside ACCESS/WAIT:** ignored.

## Structure

- Package `bus_pkg` holds:
  - `state_e` with IDLE, ACCESS, WAIT, RESP.
  - `slave_e` with RAM=2'b00, UART=2'b01, SW=2'b10, GAUSS=2'b11, matching the read-mux select encoding.
  - Base and mask constants for each address window.
- Sub-module `addr_decode` is combinational. It takes the address and write flag and returns `slave_e`, `hit` and `illegal`.
- The FSM, the timeout counter and the data capture live in `periph_bus_ctrl`.

## Test plan

- **RAM read:** `ram_rdy_i` tied 1, read `0x0000_0040`, RAM returns `0xDEAD_BEEF`.
  - Required: `select_o`=00 and `read_o`=1 for one cycle.
  - Required: `ready_o` 2 cycles after the request, `rdata_o`=`0xDEAD_BEEF`, `err_o`=0.
- **UART write with wait states:** write `0x41` to `0x0000_2000`, `uart_rdy_i` low for 3 cycles.
  - Required: `we_uart_o` high for 4 cycles and `wdata_o`=`0x41`.
  - Required: `ready_o` in cycle N+5, `rdata_o`=0.
- **Switches:** read `0x0000_2010` with `mux_data_i`=`0x0000_00A5`.
  - Required: `select_o`=10 and `rdata_o`=`0xA5` at N+2.
- **Switches write:** write to `0x0000_2010`.
  - Required: no strobe, `ready_o`+`err_o`=1 at N+1.
- **Unmapped read:** read `0x0000_3000`.
  - Required: no strobe, `err_o`=1, `rdata_o`=0 at N+1.
- **Gauss timeout, then reset:** gauss read with `gauss_rdy_i` held 0.
  - Required: `err_o`=1 exactly `TIMEOUT`+2 cycles after WAIT is entered.
  - Then repeat, asserting `rst_n_i`=0 during WAIT. Required: all outputs 0 immediately, no `ready_o`, and the next RAM read completes normally.
